// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch front end: machine width,
//   the FETCH_PACKET handed to the instruction buffer, the fetch FSM state
//   encoding (visible to benches) and a small count-clamping helper.
//   N must be a power of two and at least 2.
package fetch_unit_pkg;

  localparam int N               = 2;
  localparam int XLEN            = 32;
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  // Word offset width inside a block and the block alignment in bytes (log2)
  localparam int OFF_W           = $clog2(N);
  localparam int BLK_LSB         = $clog2(N * 4);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            valid;
  } fetch_packet_t;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DELIVER,
    FETCH_DROP
  } fetch_state_t;

  // Number of packets that can move this cycle: what the block still holds,
  // bounded by the free slots the buffer advertises.
  function automatic logic [NUM_SCALAR_BITS-1:0] clamp_count(
    input logic [NUM_SCALAR_BITS-1:0] avail,
    input logic [NUM_SCALAR_BITS-1:0] spots
  );
    return (spots < avail) ? spots : avail;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
//   Sequential-PC instruction fetcher. Requests one aligned N-word block at a
//   time, latches the returned block, and streams it to the instruction buffer
//   as up to N packets per cycle limited by the buffer's free spots. A restore
//   redirects the PC and discards any response still in flight.
//
// Ports
//   clock, reset_n        : clock, synchronous active-low reset
//   inst_buffer_spots     : free instruction-buffer slots (0..N)
//   restore_valid/_pc     : redirect request and target PC
//   inst_buffer_inputs    : packets to the buffer, oldest in slot 0
//   instructions_valid    : number of valid packets (slots 0..count-1)
//   imem_req_valid/_addr  : block request, address aligned to N*4
//   imem_req_ready        : memory accepts the request
//   imem_resp_valid/_data : returned block, word i at block_addr + 4i
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots,
  input  logic                       restore_valid,
  input  logic [XLEN-1:0]            restore_pc,
  output fetch_packet_t [N-1:0]      inst_buffer_inputs,
  output logic [NUM_SCALAR_BITS-1:0] instructions_valid,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_resp_valid,
  input  logic [N*32-1:0]            imem_resp_data
);

  fetch_state_t               state, state_next;
  logic [XLEN-1:0]            pc, pc_next;
  logic [N*32-1:0]            block;
  logic                       load_block;
  logic [OFF_W-1:0]           off;
  logic [NUM_SCALAR_BITS-1:0] avail;
  logic [NUM_SCALAR_BITS-1:0] count;

  // pc may point into the middle of a block after a misaligned redirect;
  // only words from that offset onward belong to the stream.
  assign off   = pc[BLK_LSB-1:2];
  assign avail = NUM_SCALAR_BITS'(N) - NUM_SCALAR_BITS'(off);
  assign count = (reset_n && !restore_valid && state == FETCH_DELIVER)
                 ? clamp_count(avail, inst_buffer_spots) : '0;

  assign instructions_valid = count;
  assign imem_req_valid     = reset_n && (state == FETCH_REQ);
  assign imem_req_addr      = {pc[XLEN-1:BLK_LSB], {BLK_LSB{1'b0}}};

  always_comb begin
    logic [OFF_W-1:0] widx;
    widx               = '0;
    inst_buffer_inputs = '0;
    for (int j = 0; j < N; j++) begin
      if (NUM_SCALAR_BITS'(j) < count) begin
        // j < count <= avail keeps off + j inside the block
        widx = off + OFF_W'(j);
        inst_buffer_inputs[j].inst  = block[32*widx +: 32];
        inst_buffer_inputs[j].pc    = pc + XLEN'(4 * j);
        inst_buffer_inputs[j].npc   = pc + XLEN'(4 * j + 4);
        inst_buffer_inputs[j].valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc + (XLEN'(count) << 2);
    load_block = 1'b0;
    case (state)
      FETCH_REQ:     if (imem_req_ready) state_next = FETCH_WAIT;
      FETCH_WAIT:    if (imem_resp_valid) begin
                       state_next = FETCH_DELIVER;
                       load_block = 1'b1;
                     end
      FETCH_DELIVER: if (count == avail) state_next = FETCH_REQ;
      FETCH_DROP:    if (imem_resp_valid) state_next = FETCH_REQ;
      default:       state_next = FETCH_REQ;
    endcase

    if (restore_valid) begin
      pc_next    = restore_pc;
      load_block = 1'b0;
      // A request that is (or may become) outstanding must have its response
      // swallowed. If that response shows up in the very redirect cycle it is
      // already gone, so waiting for another one would hang the front end.
      case (state)
        FETCH_REQ:  state_next = imem_req_ready  ? FETCH_DROP : FETCH_REQ;
        FETCH_WAIT: state_next = imem_resp_valid ? FETCH_REQ  : FETCH_DROP;
        FETCH_DROP: state_next = imem_resp_valid ? FETCH_REQ  : FETCH_DROP;
        default:    state_next = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= FETCH_REQ;
      pc    <= RESET_PC;
      block <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (load_block) block <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit (N = 2). A memory model answers accepted
//   block requests after a programmable latency. A stream model tracks the
//   next PC the front end owes the buffer and checks every delivered packet,
//   the request address and the per-cycle count against it.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [XLEN-1:0] RST_PC = '0;

  logic                       clock = 1'b0;
  logic                       reset_n;
  logic [NUM_SCALAR_BITS-1:0] spots;
  logic                       restore_valid;
  logic [XLEN-1:0]            restore_pc;
  fetch_packet_t [N-1:0]      ibi;
  logic [NUM_SCALAR_BITS-1:0] ivalid;
  logic                       req_valid;
  logic [XLEN-1:0]            req_addr;
  logic                       req_ready;
  logic                       resp_valid;
  logic [N*32-1:0]            resp_data;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .inst_buffer_spots  (spots),
    .restore_valid      (restore_valid),
    .restore_pc         (restore_pc),
    .inst_buffer_inputs (ibi),
    .instructions_valid (ivalid),
    .imem_req_valid     (req_valid),
    .imem_req_addr      (req_addr),
    .imem_req_ready     (req_ready),
    .imem_resp_valid    (resp_valid),
    .imem_resp_data     (resp_data)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    if (a == 32'h0) return 32'h0000_AAAA;
    if (a == 32'h4) return 32'h0000_BBBB;
    return {16'hC0DE, a[15:0]};
  endfunction

  // ---------------- memory model ----------------
  int              mem_lat = 1;
  int              n_acc = 0;
  logic            pend = 1'b0;
  int              delay = 0;
  logic [XLEN-1:0] pend_addr = '0;

  initial begin
    logic            hs, rst_seen;
    logic [XLEN-1:0] hs_addr;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clock);
      hs       = req_valid && req_ready;
      hs_addr  = req_addr;
      rst_seen = (reset_n !== 1'b1);
      @(posedge clock);
      #1;
      resp_valid = 1'b0;
      if (rst_seen) pend = 1'b0;
      else begin
        if (pend) begin
          if (delay == 0) begin
            resp_valid = 1'b1;
            for (int i = 0; i < N; i++)
              resp_data[32*i +: 32] = mem_word(pend_addr + XLEN'(4 * i));
            pend = 1'b0;
          end else delay--;
        end
        if (hs) begin
          n_acc++;
          check("single_outstanding", {63'd0, pend}, 64'd0);
          pend      = 1'b1;
          delay     = mem_lat;
          pend_addr = hs_addr;
        end
      end
    end
  end

  // ---------------- stream model / per-cycle compare ----------------
  initial begin
    logic [XLEN-1:0] exp_pc;
    int cnt, avail, exp_cnt;
    exp_pc = RST_PC;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        check("rst_ivalid", 64'(ivalid), 64'd0);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_packets_zero", 64'(ibi == '0), 64'd1);
        exp_pc = RST_PC;
      end else if (restore_valid) begin
        check("restore_ivalid", 64'(ivalid), 64'd0);
        exp_pc = restore_pc;
      end else begin
        if (req_valid)
          check("req_addr", 64'(req_addr), 64'(exp_pc & ~XLEN'(N * 4 - 1)));
        cnt   = int'(ivalid);
        avail = N - int'((exp_pc >> 2) & XLEN'(N - 1));
        exp_cnt = (int'(spots) < avail) ? int'(spots) : avail;
        if (cnt != 0) begin
          check("count", 64'(cnt), 64'(exp_cnt));
          check("no_req_while_delivering", 64'(req_valid), 64'd0);
        end
        for (int j = 0; j < N; j++) begin
          if (j < cnt) begin
            check("slot_pc", 64'(ibi[j].pc), 64'(exp_pc + XLEN'(4 * j)));
            check("slot_npc", 64'(ibi[j].npc), 64'(exp_pc + XLEN'(4 * j + 4)));
            check("slot_inst", 64'(ibi[j].inst), 64'(mem_word(exp_pc + XLEN'(4 * j))));
            check("slot_valid", 64'(ibi[j].valid), 64'd1);
          end else begin
            check("slot_empty", 64'(ibi[j] == '0), 64'd1);
          end
        end
        exp_pc = exp_pc + XLEN'(4 * cnt);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // 0: delivery, 1: request, 2: response, 3: request handshake
  task automatic wait_for(input int which, input string name);
    logic hit;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      case (which)
        0:       hit = reset_n && !restore_valid && (ivalid != 0);
        1:       hit = req_valid;
        2:       hit = resp_valid;
        default: hit = req_valid && req_ready;
      endcase
      if (hit) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not seen within 80 cycles", name);
  endtask

  initial begin
    int acc0;
    reset_n       = 1'b0;
    spots         = 2'd2;
    restore_valid = 1'b0;
    restore_pc    = '0;
    req_ready     = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_ivalid", 64'(ivalid), 64'd0);
    check("reset_req_valid", 64'(req_valid), 64'd0);

    // Cold start
    tick();
    reset_n = 1'b1;
    wait_for(1, "cold_req");
    check("cold_req_addr", 64'(req_addr), 64'h0);
    wait_for(2, "cold_resp");
    @(negedge clock);
    check("cold_cnt", 64'(ivalid), 64'd2);
    check("cold_pc0", 64'(ibi[0].pc), 64'h0);
    check("cold_pc1", 64'(ibi[1].pc), 64'h4);
    check("cold_npc0", 64'(ibi[0].npc), 64'h4);
    check("cold_npc1", 64'(ibi[1].npc), 64'h8);
    check("cold_inst0", 64'(ibi[0].inst), 64'hAAAA);
    check("cold_inst1", 64'(ibi[1].inst), 64'hBBBB);
    wait_for(1, "cold_next_req");
    check("cold_next_addr", 64'(req_addr), 64'h8);

    // Backpressure: one slot per cycle
    tick();
    spots = 2'd1;
    wait_for(0, "bp_deliv");
    check("bp_cnt0", 64'(ivalid), 64'd1);
    check("bp_pc0", 64'(ibi[0].pc), 64'h8);
    check("bp_inst0", 64'(ibi[0].inst), 64'hC0DE_0008);
    @(negedge clock);
    check("bp_cnt1", 64'(ivalid), 64'd1);
    check("bp_pc1", 64'(ibi[0].pc), 64'hC);
    check("bp_inst1", 64'(ibi[0].inst), 64'hC0DE_000C);
    wait_for(1, "bp_req");
    check("bp_req_addr", 64'(req_addr), 64'h10);

    // Stall: no spots while a block is held
    tick();
    spots = 2'd0;
    wait_for(2, "stall_resp");
    repeat (5) begin
      @(negedge clock);
      check("stall_cnt", 64'(ivalid), 64'd0);
      check("stall_req_valid", 64'(req_valid), 64'd0);
    end
    tick();
    spots     = 2'd2;
    req_ready = 1'b0;
    @(negedge clock);
    check("resume_cnt", 64'(ivalid), 64'd2);
    check("resume_pc0", 64'(ibi[0].pc), 64'h10);

    // Request stall: memory not ready for 3 cycles
    acc0 = n_acc;
    repeat (3) begin
      @(negedge clock);
      check("rs_req_valid", 64'(req_valid), 64'd1);
      check("rs_addr", 64'(req_addr), 64'h18);
    end
    tick();
    req_ready = 1'b1;
    wait_for(0, "rs_deliv");
    check("rs_one_accept", 64'(n_acc - acc0), 64'd1);
    check("rs_cnt", 64'(ivalid), 64'd2);
    check("rs_pc0", 64'(ibi[0].pc), 64'h18);

    // Redirect while a response is in flight
    tick();
    mem_lat = 4;
    wait_for(3, "redir_hs");
    tick();
    restore_valid = 1'b1;
    restore_pc    = 32'h104;
    @(negedge clock);
    check("redir_ivalid", 64'(ivalid), 64'd0);
    tick();
    restore_valid = 1'b0;
    wait_for(1, "redir_req");
    check("redir_req_addr", 64'(req_addr), 64'h100);
    wait_for(0, "redir_deliv");
    check("redir_cnt", 64'(ivalid), 64'd1);
    check("redir_pc", 64'(ibi[0].pc), 64'h104);
    check("redir_npc", 64'(ibi[0].npc), 64'h108);
    check("redir_inst", 64'(ibi[0].inst), 64'hC0DE_0104);

    // Reset in the middle of a partially delivered block
    tick();
    spots = 2'd1;
    wait_for(0, "rmd_deliv");
    check("rmd_pc_before", 64'(ibi[0].pc), 64'h108);
    tick();
    reset_n = 1'b0;
    @(negedge clock);
    check("rmd_ivalid", 64'(ivalid), 64'd0);
    check("rmd_req_valid", 64'(req_valid), 64'd0);
    tick();
    reset_n = 1'b1;
    spots   = 2'd2;
    wait_for(1, "rmd_req");
    check("rmd_req_addr", 64'(req_addr), 64'h0);
    wait_for(0, "rmd_deliv2");
    check("rmd_cnt", 64'(ivalid), 64'd2);
    check("rmd_inst0", 64'(ibi[0].inst), 64'hAAAA);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
